// File: rtl/vending_controller_pkg.sv
// Shared defaults and state encoding for the vending machine transaction sequencer.
// The inactivity timeout is compiled in only when VENDING_TIMEOUT_EN is defined.
package vending_controller_pkg;

    localparam int kDefNumCoins   = 3;
    localparam int kDefNumItems   = 4;
    localparam int kDefWaitTime   = 100;
    localparam int kDefTotalWidth = 16;

    localparam logic [kDefNumCoins-1:0][31:0] kDefCoinValue = {32'd1000, 32'd500, 32'd100};
    localparam logic [kDefNumItems-1:0][31:0] kDefItemPrice = {32'd2000, 32'd1000, 32'd500, 32'd400};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RETURN  = 2'd2
    } state_t;

endpackage

// File: rtl/vending_controller_change_selector.sv
// change_selector: picks the largest coin whose value fits in the balance.
// Purely combinational; coin values need not be sorted.
module change_selector
    import vending_controller_pkg::*;
#(
    parameter int                         kNumCoins   = kDefNumCoins,
    parameter int                         kTotalWidth = kDefTotalWidth,
    parameter logic [kNumCoins-1:0][31:0] kCoinValue  = kDefCoinValue
) (
    input  logic [kTotalWidth-1:0] balance,
    output logic [kNumCoins-1:0]   coin,
    output logic [kTotalWidth-1:0] value
);

    localparam int kCmpW = ((kTotalWidth > 32) ? kTotalWidth : 32) + 1;

    logic [kCmpW-1:0] best;

    always_comb begin
        coin = '0;
        best = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if ((kCmpW'(kCoinValue[i]) <= kCmpW'(balance)) && (kCmpW'(kCoinValue[i]) > best)) begin
                best    = kCmpW'(kCoinValue[i]);
                coin    = '0;
                coin[i] = 1'b1;
            end
        end
        value = best[kTotalWidth-1:0];
    end

endmodule

// File: rtl/vending_controller.sv
// vending_controller: coin accumulation, item dispense and largest-first change payout.
// Define VENDING_TIMEOUT_EN to enable the inactivity timeout counter.
module vending_controller
    import vending_controller_pkg::*;
#(
    parameter int                         kNumCoins   = kDefNumCoins,
    parameter int                         kNumItems   = kDefNumItems,
    parameter int                         kWaitTime   = kDefWaitTime,
    parameter logic [kNumCoins-1:0][31:0] kCoinValue  = kDefCoinValue,
    parameter logic [kNumItems-1:0][31:0] kItemPrice  = kDefItemPrice,
    parameter int                         kTotalWidth = kDefTotalWidth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [kNumCoins-1:0]   i_input_coin,
    input  logic [kNumItems-1:0]   i_select_item,
    input  logic                   i_trigger_return,
    output logic [kNumItems-1:0]   o_available_item,
    output logic [kNumItems-1:0]   o_output_item,
    output logic [kNumCoins-1:0]   o_return_coin,
    output logic [kTotalWidth-1:0] o_current_total,
    output logic [31:0]            o_wait_time,
    output logic                   o_busy
);

    // Extra headroom so a whole cycle's coins can be summed before the overflow check.
    localparam int               kExtW     = ((kTotalWidth > 32) ? kTotalWidth : 32) + 3;
    localparam logic [kExtW-1:0] kMaxTotal = {{(kExtW - kTotalWidth){1'b0}}, {kTotalWidth{1'b1}}};

    state_t                 state, state_next;
    logic [kTotalWidth-1:0] balance, balance_next;
    logic [kNumItems-1:0]   output_item, item_next, affordable;
    logic [kNumCoins-1:0]   return_coin, coin_next, change_coin;
    logic [kTotalWidth-1:0] change_value;
    logic                   busy, busy_next;
    logic [kExtW-1:0]       coin_sum, price_sel, after_sel, with_coins;
    logic                   sel_valid, coin_ok, reload, timeout;
    logic [31:0]            wait_time;

    change_selector #(
        .kNumCoins   (kNumCoins),
        .kTotalWidth (kTotalWidth),
        .kCoinValue  (kCoinValue)
    ) u_change_selector (
        .balance (balance),
        .coin    (change_coin),
        .value   (change_value)
    );

    always_comb begin
        affordable = '0;
        price_sel  = '0;
        coin_sum   = '0;
        for (int i = 0; i < kNumItems; i++) begin
            affordable[i] = (kExtW'(balance) >= kExtW'(kItemPrice[i]));
            if (i_select_item[i]) begin
                price_sel = kExtW'(kItemPrice[i]);
            end
        end
        for (int i = 0; i < kNumCoins; i++) begin
            if (i_input_coin[i]) begin
                coin_sum = coin_sum + kExtW'(kCoinValue[i]);
            end
        end
    end

    // Affordability uses the registered balance, so a coin arriving with a selection cannot fund it.
    assign sel_valid  = $onehot(i_select_item) && ((i_select_item & affordable) != '0);
    assign after_sel  = kExtW'(balance) - (sel_valid ? price_sel : '0);
    assign with_coins = after_sel + coin_sum;
    assign coin_ok    = (state != ST_RETURN) && (i_input_coin != '0) && (with_coins <= kMaxTotal);
    assign reload     = (state != ST_RETURN) && (coin_ok || sel_valid);

    always_comb begin
        state_next   = state;
        balance_next = balance;
        item_next    = '0;
        coin_next    = '0;
        busy_next    = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                balance_next = coin_ok ? with_coins[kTotalWidth-1:0] : after_sel[kTotalWidth-1:0];
                item_next    = sel_valid ? i_select_item : '0;
                if (balance_next == '0) begin
                    state_next = ST_IDLE;
                end else if (state == ST_IDLE) begin
                    state_next = ST_COLLECT;
                end else if (i_trigger_return || (timeout && !reload)) begin
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                // An unpayable remainder cannot occur with well-formed coin values; drop it if it does.
                if (change_coin == '0) begin
                    state_next   = ST_IDLE;
                    balance_next = '0;
                end else begin
                    coin_next    = change_coin;
                    balance_next = balance - change_value;
                    busy_next    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            balance     <= '0;
            output_item <= '0;
            return_coin <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            balance     <= balance_next;
            output_item <= item_next;
            return_coin <= coin_next;
            busy        <= busy_next;
        end
    end

`ifdef VENDING_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_time <= 32'(kWaitTime);
        end else if ((state_next != ST_COLLECT) || reload) begin
            wait_time <= 32'(kWaitTime);
        end else if (wait_time != '0) begin
            wait_time <= wait_time - 32'd1;
        end
    end

    assign timeout = (wait_time == '0);
`else
    assign wait_time = 32'(kWaitTime);
    assign timeout   = 1'b0;
`endif

    assign o_available_item = (state == ST_RETURN) ? '0 : affordable;
    assign o_output_item    = output_item;
    assign o_return_coin    = return_coin;
    assign o_current_total  = balance;
    assign o_wait_time      = wait_time;
    assign o_busy           = busy;

endmodule

// File: tb/tb_vending_controller.sv
// Directed self-checking bench for vending_controller with hand-computed expectations.
// Timeout-dependent expectations follow VENDING_TIMEOUT_EN.
module tb_vending_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  input_coin;
    logic [3:0]  select_item;
    logic        trigger_return;
    logic [3:0]  available_item;
    logic [3:0]  output_item;
    logic [2:0]  return_coin;
    logic [15:0] current_total;
    logic [31:0] wait_time;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef VENDING_TIMEOUT_EN
    localparam bit kTimeoutEn = 1'b1;
`else
    localparam bit kTimeoutEn = 1'b0;
`endif

    vending_controller dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (input_coin),
        .i_select_item    (select_item),
        .i_trigger_return (trigger_return),
        .o_available_item (available_item),
        .o_output_item    (output_item),
        .o_return_coin    (return_coin),
        .o_current_total  (current_total),
        .o_wait_time      (wait_time),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge sample them, then sample outputs 1ns later.
    task automatic applyStimulus(input logic [2:0] coin, input logic [3:0] sel, input logic trig);
        @(negedge clk);
        input_coin     = coin;
        select_item    = sel;
        trigger_return = trig;
        @(posedge clk);
        #1;
        input_coin     = '0;
        select_item    = '0;
        trigger_return = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the directed sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int coins_seen;
        int big_coins;

        reset          = 1'b1;
        input_coin     = '0;
        select_item    = '0;
        trigger_return = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_total", current_total, 0);
        checkOutput("rst_item", output_item, 0);
        checkOutput("rst_coin", return_coin, 0);
        checkOutput("rst_wait", wait_time, 100);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_avail", available_item, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] insert 500, 100 then buy item 0");
        applyStimulus(3'b010, 4'b0000, 1'b0);
        checkOutput("t1_total_500", current_total, 500);
        checkOutput("t1_avail_500", available_item, 4'b0011);
        applyStimulus(3'b001, 4'b0000, 1'b0);
        checkOutput("t1_total_600", current_total, 600);
        checkOutput("t1_avail_600", available_item, 4'b0011);
        applyStimulus(3'b000, 4'b0001, 1'b0);
        checkOutput("t1_total_200", current_total, 200);
        checkOutput("t1_pulse", output_item, 4'b0001);
        checkOutput("t1_avail_200", available_item, 4'b0000);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t1_pulse_end", output_item, 4'b0000);
        applyStimulus(3'b000, 4'b0000, 1'b1);
        checkOutput("t1_ret_enter_coin", return_coin, 3'b000);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t1_ret_coin1", return_coin, 3'b001);
        checkOutput("t1_ret_total1", current_total, 100);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t1_ret_coin2", return_coin, 3'b001);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t1_ret_done_coin", return_coin, 3'b000);
        checkOutput("t1_ret_done_busy", busy, 0);

        $display("[TB] insert 1000+500+100 together then return");
        applyStimulus(3'b111, 4'b0000, 1'b0);
        checkOutput("t2_total", current_total, 1600);
        checkOutput("t2_avail", available_item, 4'b0111);
        applyStimulus(3'b000, 4'b0000, 1'b1);
        checkOutput("t2_enter_coin", return_coin, 3'b000);
        checkOutput("t2_enter_busy", busy, 0);
        checkOutput("t2_avail_forced", available_item, 4'b0000);
        applyStimulus(3'b001, 4'b0001, 1'b1);
        checkOutput("t2_coin_1000", return_coin, 3'b100);
        checkOutput("t2_total_600", current_total, 600);
        checkOutput("t2_busy1", busy, 1);
        checkOutput("t2_no_dispense", output_item, 4'b0000);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t2_coin_500", return_coin, 3'b010);
        checkOutput("t2_busy2", busy, 1);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t2_coin_100", return_coin, 3'b001);
        checkOutput("t2_total_0", current_total, 0);
        checkOutput("t2_busy3", busy, 1);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t2_coin_end", return_coin, 3'b000);
        checkOutput("t2_busy_end", busy, 0);

        $display("[TB] insert 100 then stay idle");
        applyStimulus(3'b001, 4'b0000, 1'b0);
        checkOutput("t3_total", current_total, 100);
        checkOutput("t3_wait_reload", wait_time, 100);
        repeat (100) applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t3_wait_end", wait_time, kTimeoutEn ? 0 : 100);
        checkOutput("t3_total_hold", current_total, 100);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t3_edge_coin", return_coin, 3'b000);
        checkOutput("t3_edge_wait", wait_time, 100);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t3_timeout_coin", return_coin, kTimeoutEn ? 3'b001 : 3'b000);
        checkOutput("t3_timeout_total", current_total, kTimeoutEn ? 0 : 100);
        applyStimulus(3'b000, 4'b0000, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t3_clean_total", current_total, 0);
        checkOutput("t3_clean_busy", busy, 0);

        $display("[TB] balance 400, buy item 0 and insert 500 together");
        repeat (4) applyStimulus(3'b001, 4'b0000, 1'b0);
        checkOutput("t4_total_400", current_total, 400);
        checkOutput("t4_avail_400", available_item, 4'b0001);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t4_wait_dec", wait_time, kTimeoutEn ? 99 : 100);
        applyStimulus(3'b010, 4'b0001, 1'b0);
        checkOutput("t4_pulse", output_item, 4'b0001);
        checkOutput("t4_total_500", current_total, 500);
        checkOutput("t4_wait_reload", wait_time, 100);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t4_pulse_end", output_item, 4'b0000);

        $display("[TB] invalid selections at balance 1000");
        applyStimulus(3'b010, 4'b0000, 1'b0);
        checkOutput("t5_total_1000", current_total, 1000);
        checkOutput("t5_avail", available_item, 4'b0111);
        checkOutput("t5_wait_reload", wait_time, 100);
        applyStimulus(3'b000, 4'b0011, 1'b0);
        checkOutput("t5_multi_pulse", output_item, 4'b0000);
        checkOutput("t5_multi_total", current_total, 1000);
        checkOutput("t5_multi_wait", wait_time, kTimeoutEn ? 99 : 100);
        applyStimulus(3'b000, 4'b1000, 1'b0);
        checkOutput("t5_poor_pulse", output_item, 4'b0000);
        checkOutput("t5_poor_total", current_total, 1000);
        checkOutput("t5_poor_wait", wait_time, kTimeoutEn ? 98 : 100);
        applyStimulus(3'b000, 4'b0000, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t5_ret_coin", return_coin, 3'b100);
        checkOutput("t5_ret_total", current_total, 0);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t5_ret_end", busy, 0);

        $display("[TB] balance overflow rejection");
        repeat (40) applyStimulus(3'b111, 4'b0000, 1'b0);
        checkOutput("t6_total_64000", current_total, 64000);
        checkOutput("t6_avail", available_item, 4'b1111);
        applyStimulus(3'b111, 4'b0000, 1'b0);
        checkOutput("t6_reject_total", current_total, 64000);
        checkOutput("t6_reject_wait", wait_time, kTimeoutEn ? 99 : 100);
        applyStimulus(3'b010, 4'b0000, 1'b0);
        checkOutput("t6_total_64500", current_total, 64500);
        applyStimulus(3'b100, 4'b0000, 1'b0);
        checkOutput("t6_total_65500", current_total, 65500);
        applyStimulus(3'b001, 4'b0000, 1'b0);
        checkOutput("t6_reject2_total", current_total, 65500);
        applyStimulus(3'b000, 4'b0000, 1'b1);
        coins_seen = 0;
        big_coins  = 0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus(3'b000, 4'b0000, 1'b0);
            if (return_coin != 3'b000) coins_seen++;
            if (return_coin == 3'b100) big_coins++;
            if (coins_seen > 0 && !busy) break;
        end
        checkOutput("t6_coin_count", coins_seen, 66);
        checkOutput("t6_big_coins", big_coins, 65);
        checkOutput("t6_drained_total", current_total, 0);
        checkOutput("t6_drained_busy", busy, 0);

        $display("[TB] reset during payout");
        applyStimulus(3'b111, 4'b0000, 1'b0);
        applyStimulus(3'b000, 4'b0000, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t7_first_coin", return_coin, 3'b100);
        checkOutput("t7_total_600", current_total, 600);
        reset = 1'b1;
        #2;
        checkOutput("t7_rst_total", current_total, 0);
        checkOutput("t7_rst_coin", return_coin, 0);
        checkOutput("t7_rst_busy", busy, 0);
        checkOutput("t7_rst_item", output_item, 0);
        checkOutput("t7_rst_wait", wait_time, 100);
        checkOutput("t7_rst_avail", available_item, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(3'b000, 4'b0000, 1'b0);
        applyStimulus(3'b000, 4'b0000, 1'b0);
        checkOutput("t7_idle_coin", return_coin, 0);
        checkOutput("t7_idle_busy", busy, 0);
        checkOutput("t7_idle_total", current_total, 0);
        applyStimulus(3'b010, 4'b0000, 1'b0);
        checkOutput("t7_fresh_total", current_total, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
